// File: rtl/phy_cc_pkg.sv
// Shared definitions for the PD PHY CC line access controller.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, line owner encoding, default timing
// parameters and width helpers used to size the timer and retry counter.
package phy_cc_pkg;

  localparam int IFG_CYCLES_DEF     = 25;
  localparam int BACKOFF_CYCLES_DEF = 64;
  localparam int MAX_RETRY_DEF      = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_BACKOFF = 3'd2,
    ST_GRANT   = 3'd3,
    ST_IFG     = 3'd4
  } cc_state_t;

  typedef enum logic {
    OWN_PROT = 1'b0,
    OWN_HRST = 1'b1
  } cc_owner_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..maxval, never less than one bit.
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/phy_cc_timer.sv
// Loadable down-counter with a zero flag, shared by the BACKOFF and IFG waits.
// Latency: load takes effect on the next clk edge; zero is decoded from the count register.
// Backpressure: none; dec is ignored once the count reaches zero (no wrap).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (count -> 0)
//   load, load_val load a new count (load wins over dec)
//   dec            decrement request
//   zero           count == 0
module phy_cc_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/phy_cc_access_ctrl.sv
// Arbitrates CC line access between protocol and hard-reset transmit requests.
// Latency: request -> det_en 1 cycle; det_done -> gnt/fail 1 cycle; tx_done -> gnt low 1 cycle.
// Backpressure: requests are levels held by the requester; they wait in BACKOFF/GRANT/IFG.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   prot_req, hrst_req     transmit requests (level); hard reset has priority
//   prot_gnt, hrst_gnt     line granted (level, held until tx_done)
//   prot_fail, hrst_fail   one-cycle pulse: request abandoned after retries
//   tx_done                frame finished (pulse), only honoured in GRANT
//   det_en                 idle detector enable, held for a whole window
//   det_done, det_result   detector window complete / line idle
//   busy                   controller not in IDLE
// Every output is a flop; no input reaches an output combinationally.
module phy_cc_access_ctrl
  import phy_cc_pkg::*;
#(
  parameter int IFG_CYCLES     = IFG_CYCLES_DEF,     // >= 1
  parameter int BACKOFF_CYCLES = BACKOFF_CYCLES_DEF, // >= 1
  parameter int MAX_RETRY      = MAX_RETRY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic prot_req,
  input  logic hrst_req,
  output logic prot_gnt,
  output logic hrst_gnt,
  output logic prot_fail,
  output logic hrst_fail,
  input  logic tx_done,
  output logic det_en,
  input  logic det_done,
  input  logic det_result,
  output logic busy
);

  localparam int TW = cnt_width(max_int(IFG_CYCLES, BACKOFF_CYCLES));
  localparam int RW = cnt_width(MAX_RETRY);

  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  // The load lands on the edge that enters the wait state, so the first
  // cycle in that state already sees N-1; loading N-1 makes the wait state
  // last exactly N cycles before the zero flag moves the FSM on.
  localparam logic [TW-1:0] BACKOFF_LOAD = TW'((BACKOFF_CYCLES > 0) ? BACKOFF_CYCLES - 1 : 0);
  localparam logic [TW-1:0] IFG_LOAD     = TW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  cc_state_t       state;
  cc_owner_t       owner;
  logic [RW-1:0]   retry_cnt;

  logic            own_req;
  logic            busy_retry;
  logic            tmr_load;
  logic [TW-1:0]   tmr_load_val;
  logic            tmr_dec;
  logic            tmr_zero;

  always_comb begin
    own_req      = (owner == OWN_HRST) ? hrst_req : prot_req;
    // A busy result that still has retries left goes to BACKOFF.
    busy_retry   = (state == ST_CHECK) && det_done && !det_result && (retry_cnt != RETRY_LIMIT);
    tmr_load     = busy_retry || ((state == ST_GRANT) && tx_done);
    tmr_load_val = (state == ST_GRANT) ? IFG_LOAD : BACKOFF_LOAD;
    tmr_dec      = (state == ST_BACKOFF) || (state == ST_IFG);
  end

  phy_cc_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Outputs are assigned alongside each state transition so they always
  // reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= OWN_PROT;
      retry_cnt <= '0;
      prot_gnt  <= 1'b0;
      hrst_gnt  <= 1'b0;
      prot_fail <= 1'b0;
      hrst_fail <= 1'b0;
      det_en    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      prot_fail <= 1'b0;
      hrst_fail <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (hrst_req) begin
            state     <= ST_CHECK;
            owner     <= OWN_HRST;
            retry_cnt <= '0;
            det_en    <= 1'b1;
            busy      <= 1'b1;
          end else if (prot_req) begin
            state     <= ST_CHECK;
            owner     <= OWN_PROT;
            retry_cnt <= '0;
            det_en    <= 1'b1;
            busy      <= 1'b1;
          end
        end

        // det_en stays high for the whole window; the detector only clears
        // its counters on det_done.
        ST_CHECK: begin
          if (det_done) begin
            det_en <= 1'b0;
            if (det_result) begin
              state    <= ST_GRANT;
              prot_gnt <= (owner == OWN_PROT);
              hrst_gnt <= (owner == OWN_HRST);
            end else if (retry_cnt == RETRY_LIMIT) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              prot_fail <= (owner == OWN_PROT);
              hrst_fail <= (owner == OWN_HRST);
            end else begin
              // Only reached below the limit, so the count never wraps.
              state     <= ST_BACKOFF;
              retry_cnt <= retry_cnt + 1'b1;
            end
          end
        end

        // Withdrawal beats preemption beats timer expiry.
        ST_BACKOFF: begin
          if (!own_req) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if ((owner == OWN_PROT) && hrst_req) begin
            // The protocol request stays pending and is re-served from IDLE.
            state     <= ST_CHECK;
            owner     <= OWN_HRST;
            retry_cnt <= '0;
            det_en    <= 1'b1;
          end else if (tmr_zero) begin
            state  <= ST_CHECK;
            det_en <= 1'b1;
          end
        end

        ST_GRANT: begin
          if (tx_done) begin
            state    <= ST_IFG;
            prot_gnt <= 1'b0;
            hrst_gnt <= 1'b0;
          end
        end

        ST_IFG: begin
          if (tmr_zero) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          prot_gnt <= 1'b0;
          hrst_gnt <= 1'b0;
          det_en   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phy_cc_access_ctrl.sv
// Self-checking bench for phy_cc_access_ctrl.
// Scenarios are expanded into per-cycle stimulus and expected-output queues
// from the access rules (window lengths, backoff/IFG durations, retry limit),
// then replayed against the DUT one clock period at a time.
module tb_phy_cc_access_ctrl;
  import phy_cc_pkg::*;

  localparam int IFG = IFG_CYCLES_DEF;
  localparam int BO  = BACKOFF_CYCLES_DEF;
  localparam int MR  = MAX_RETRY_DEF;

  logic clk;
  logic rst_n;
  logic prot_req, hrst_req, tx_done, det_done, det_result;
  logic prot_gnt, hrst_gnt, prot_fail, hrst_fail, det_en, busy;

  typedef struct packed {
    logic prot_req;
    logic hrst_req;
    logic tx_done;
    logic det_done;
    logic det_result;
  } stim_t;

  typedef struct packed {
    logic prot_gnt;
    logic hrst_gnt;
    logic prot_fail;
    logic hrst_fail;
    logic det_en;
    logic busy;
  } obs_t;

  obs_t obs;
  assign obs = {prot_gnt, hrst_gnt, prot_fail, hrst_fail, det_en, busy};

  phy_cc_access_ctrl #(
    .IFG_CYCLES     (IFG),
    .BACKOFF_CYCLES (BO),
    .MAX_RETRY      (MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prot_req   (prot_req),
    .hrst_req   (hrst_req),
    .prot_gnt   (prot_gnt),
    .hrst_gnt   (hrst_gnt),
    .prot_fail  (prot_fail),
    .hrst_fail  (hrst_fail),
    .tx_done    (tx_done),
    .det_en     (det_en),
    .det_done   (det_done),
    .det_result (det_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stim_t sq[$];
  obs_t  oq[$];
  obs_t  pend;      // fail pulse to show in the next emitted (IDLE) period
  int    force_w;   // fixed detector window length, 0 = random
  int    gidx;      // index of the first GRANT period of the scenario
  int    n_chk;
  int    n_err;

  task automatic chk(input string tag, input obs_t got, input obs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %06b expected %06b (pgnt hgnt pfail hfail det_en busy)", tag, got, exp);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic obs_t mk(input bit pg, input bit hg, input bit pf, input bit hf,
                              input bit de, input bit b);
    obs_t o;
    o.prot_gnt = pg; o.hrst_gnt = hg; o.prot_fail = pf;
    o.hrst_fail = hf; o.det_en = de; o.busy = b;
    return o;
  endfunction

  // Requests as given, with random noise on inputs that must be ignored.
  function automatic stim_t stray(input bit pr, input bit hr);
    stim_t s;
    s.prot_req = pr; s.hrst_req = hr;
    s.tx_done = rb(); s.det_done = rb(); s.det_result = rb();
    return s;
  endfunction

  task automatic emit(input stim_t s, input obs_t o);
    obs_t t;
    t = o | pend;
    pend = '0;
    sq.push_back(s);
    oq.push_back(t);
  endtask

  task automatic gen_idle(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = (i == n - 1) ? stim_t'(0) : stray(1'b0, 1'b0);
      emit(s, mk(0, 0, 0, 0, 0, 0));
    end
  endtask

  // One request served from start to finish.
  //   hrst       owner is the hard-reset requester
  //   pp         protocol request pending alongside a hard-reset owner
  //   nbusy      busy results before the first idle one (> MR means fail)
  //   abort_kind 0 none, 1 hrst preempts, 2 owner withdraws; during backoff abort_bo
  //   start_idle emit the IDLE period in which the request is sampled
  task automatic gen_txn(input bit hrst, input bit pp, input int nbusy,
                         input int abort_kind, input int abort_bo, input bit start_idle);
    stim_t s;
    int    nchk, w, g, ab_k;
    bit    pr, hr;
    pr   = hrst ? pp : 1'b1;
    hr   = hrst;
    ab_k = $urandom_range(0, BO - 1);
    nchk = (nbusy > MR) ? MR + 1 : nbusy + 1;
    if (start_idle) begin
      s = '0; s.prot_req = pr; s.hrst_req = hr; s.tx_done = rb();
      emit(s, mk(0, 0, 0, 0, 0, 0));
    end
    for (int i = 0; i < nchk; i++) begin
      w = (force_w > 0) ? force_w : $urandom_range(1, 20);
      for (int j = 0; j < w; j++) begin
        s.prot_req   = pr;
        s.hrst_req   = hr;
        s.tx_done    = rb();
        s.det_done   = (j == w - 1);
        s.det_result = (j == w - 1) ? (i == nbusy) : rb();
        emit(s, mk(0, 0, 0, 0, 1, 1));
      end
      if (i == nbusy) break;
      if (i == MR) begin
        pend = hrst ? mk(0, 0, 0, 1, 0, 0) : mk(0, 0, 1, 0, 0, 0);
        return;
      end
      for (int k = 0; k < BO; k++) begin
        s = stray(pr, hr);
        if (abort_kind != 0 && abort_bo == i && k == ab_k) begin
          if (abort_kind == 1) s.hrst_req = 1'b1;
          else if (hrst)       s.hrst_req = 1'b0;
          else                 s.prot_req = 1'b0;
          emit(s, mk(0, 0, 0, 0, 0, 1));
          return;
        end
        emit(s, mk(0, 0, 0, 0, 0, 1));
      end
    end
    g = $urandom_range(1, 12);
    for (int k = 0; k < g; k++) begin
      s = stray(hrst ? pp : rb(), hrst ? rb() : 1'b0);
      s.tx_done = (k == g - 1);
      if (gidx < 0) gidx = sq.size();
      emit(s, mk(!hrst, hrst, 0, 0, 0, 1));
    end
    for (int k = 0; k < IFG; k++) begin
      s = stray(hrst ? pp : 1'b0, 1'b0);
      emit(s, mk(0, 0, 0, 0, 0, 1));
    end
  endtask

  task automatic drive(input stim_t s);
    prot_req = s.prot_req; hrst_req = s.hrst_req; tx_done = s.tx_done;
    det_done = s.det_done; det_result = s.det_result;
  endtask

  task automatic do_reset();
    drive('0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Per period: compare outputs, then apply that period's inputs.
  task automatic play(input string name, input int upto, output bit bad);
    int e0;
    bad = 1'b0;
    for (int p = 0; p < upto; p++) begin
      @(negedge clk);
      e0 = n_err;
      chk($sformatf("%s[%0d]", name, p), obs, oq[p]);
      if (n_err != e0) begin
        bad = 1'b1;
        break;
      end
      drive(sq[p]);
    end
  endtask

  task automatic run_scn(input string name);
    bit bad;
    play(name, sq.size(), bad);
    if (bad) do_reset();
    sq.delete();
    oq.delete();
    pend    = '0;
    gidx    = -1;
    force_w = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int kind, nb, nb2, bo;
    bit h, bad;
    n_chk = 0; n_err = 0; pend = '0; gidx = -1; force_w = 0;
    rst_n = 1'b0;
    drive('0);
    repeat (3) @(negedge clk);
    chk("reset_hold", obs, mk(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release", obs, mk(0, 0, 0, 0, 0, 0));

    // Idle line, 31-cycle detector window.
    force_w = 31;
    gen_txn(1'b0, 1'b0, 0, 0, 0, 1'b1); gen_idle(2);
    run_scn("idle_line");

    // Busy line: MR+1 windows then one prot_fail.
    gen_txn(1'b0, 1'b0, MR + 1, 0, 0, 1'b1); gen_idle(3);
    run_scn("busy_line");

    // Simultaneous requests: HRST first, PROT after its IFG.
    gen_txn(1'b1, 1'b1, 0, 0, 0, 1'b1);
    gen_txn(1'b0, 1'b0, 0, 0, 0, 1'b1); gen_idle(2);
    run_scn("priority");

    // Preemption during the first backoff.
    gen_txn(1'b0, 1'b0, 1, 1, 0, 1'b1);
    gen_txn(1'b1, 1'b1, 0, 0, 0, 1'b0);
    gen_txn(1'b0, 1'b0, 0, 0, 0, 1'b1); gen_idle(2);
    run_scn("preempt");

    // Withdrawal during backoff, followed by idle periods with stray tx_done.
    gen_txn(1'b0, 1'b0, 2, 2, 1, 1'b1); gen_idle(4);
    run_scn("withdraw");

    // Asynchronous reset in GRANT, then a fresh request.
    gen_txn(1'b0, 1'b0, 0, 0, 0, 1'b1);
    play("rst_grant", gidx + 1, bad);
    if (!bad) begin
      #1 rst_n = 1'b0;
      drive('0);
      #1 chk("rst_async", obs, mk(0, 0, 0, 0, 0, 0));
      @(negedge clk);
      chk("rst_held", obs, mk(0, 0, 0, 0, 0, 0));
      rst_n = 1'b1;
    end else begin
      do_reset();
    end
    sq.delete(); oq.delete(); pend = '0; gidx = -1;
    gen_txn(1'b0, 1'b0, 0, 0, 0, 1'b1); gen_idle(2);
    run_scn("after_rst");

    for (int r = 0; r < 24; r++) begin
      kind = $urandom_range(0, 3);
      nb   = $urandom_range(0, MR + 1);
      nb2  = $urandom_range(0, MR + 1);
      h    = rb();
      case (kind)
        0: begin
          gen_txn(h, 1'b0, nb, 0, 0, 1'b1);
        end
        1: begin
          gen_txn(1'b1, 1'b1, nb, 0, 0, 1'b1);
          gen_txn(1'b0, 1'b0, nb2, 0, 0, 1'b1);
        end
        2: begin
          nb = $urandom_range(1, MR + 1);
          bo = $urandom_range(0, imin(nb, MR) - 1);
          gen_txn(1'b0, 1'b0, nb, 1, bo, 1'b1);
          gen_txn(1'b1, 1'b1, nb2, 0, 0, 1'b0);
          gen_txn(1'b0, 1'b0, $urandom_range(0, MR + 1), 0, 0, 1'b1);
        end
        default: begin
          nb = $urandom_range(1, MR + 1);
          bo = $urandom_range(0, imin(nb, MR) - 1);
          gen_txn(h, 1'b0, nb, 2, bo, 1'b1);
        end
      endcase
      gen_idle(3);
      run_scn($sformatf("rand%0d_k%0d", r, kind));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/phy_cc_access_ctrl.md
# phy_cc_access_ctrl

Sequences access to the CC line for the PD PHY transmit path. It arbitrates between a protocol-layer transmit request and a hard-reset transmit request. For each request it runs the CC idle detector, then either grants the line or backs off and retries. After every transmission it enforces an inter-frame gap. It sits between the protocol/hard-reset request logic and the idle detector / BMC transmitter.

## Interface
- IFG_CYCLES, 25: inter-frame gap, in clk cycles, after tx_done.
- BACKOFF_CYCLES, 64: wait between a busy-line result and the next idle check.
- MAX_RETRY, 3: busy results tolerated before a request fails. 0 means fail on the first busy result.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- prot_req  in  1  protocol transmit request, level, held until grant or fail.
- hrst_req  in  1  hard-reset transmit request, level; has priority.
- prot_gnt  out  1  line granted to protocol transmitter, level.
- hrst_gnt  out  1  line granted to hard-reset transmitter, level.
- prot_fail  out  1  one-cycle pulse: protocol request abandoned, retries exhausted.
- hrst_fail  out  1  one-cycle pulse: hard-reset request abandoned.
- tx_done  in  1  one-cycle pulse from transmitter: frame finished.
- det_en  out  1  enable to the idle detector.
- det_done  in  1  detector window complete (combinational in the detector).
- det_result  in  1  1 = line idle, valid when det_done = 1.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, CHECK, BACKOFF, GRANT, IFG. Internal registers: owner (PROT/HRST) and retry_cnt.
- IDLE:
  - hrst_req -> CHECK with owner = HRST.
  - Otherwise prot_req -> CHECK with owner = PROT.
  - retry_cnt cleared on entry to CHECK from IDLE.
- CHECK: det_en = 1 continuously until det_done. The detector only clears its counters on done, so det_en never drops mid-window. Sampled in the det_done cycle:
  - det_result = 1 -> GRANT.
  - det_result = 0 and retry_cnt == MAX_RETRY -> fail pulse for owner, then IDLE.
  - det_result = 0 otherwise -> retry_cnt + 1, then BACKOFF.
- BACKOFF: timer loads BACKOFF_CYCLES; state -> CHECK when the timer reaches 0.
  - Owner's request deasserted -> IDLE, no fail pulse.
  - Owner = PROT and hrst_req = 1 -> preempt: owner = HRST, retry_cnt = 0, CHECK next cycle. The PROT request remains pending.
- GRANT: the owner's gnt is held. tx_done -> IFG. Request deassertion in GRANT is ignored.
- IFG: timer loads IFG_CYCLES; state -> IDLE at 0. Requests wait.
- tx_done outside GRANT is ignored. det_done outside CHECK is ignored.

## Timing
- Reset: state IDLE. prot_gnt, hrst_gnt, prot_fail, hrst_fail, det_en, busy all 0. Counters 0.
- All outputs are decoded from registers. There is no combinational path from any input to any output.
- Request to det_en: 1 cycle (request sampled in IDLE, det_en high the next cycle).
- det_done to gnt or fail: 1 cycle. det_en falls in the same cycle gnt/fail appears.
- BACKOFF lasts exactly BACKOFF_CYCLES cycles.
- tx_done to gnt low: 1 cycle. gnt low to earliest next det_en: IFG_CYCLES + 1 cycles.
- Simultaneous prot_req and hrst_req in IDLE: HRST wins. PROT is served after HRST's GRANT/IFG or fail.
- Reset mid-CHECK or mid-GRANT: immediate return to reset values. The detector's own reset clears its window.
- Widths:
  - Timer width = $clog2(max(IFG_CYCLES, BACKOFF_CYCLES) + 1).
  - retry_cnt width = $clog2(MAX_RETRY + 1), minimum 1. It saturates and never wraps.

## Structure
- Shared package phy_cc_pkg holds:
  - state encoding (5-state enum)
  - owner enum
  - default values of IFG_CYCLES, BACKOFF_CYCLES and MAX_RETRY
- One sub-module: phy_cc_timer, a loadable down-counter with a zero flag. Load value is a port; a single instance serves both BACKOFF and IFG.

## Test plan
- Idle line: prot_req = 1, detector returns done with result = 1 after 31 cycles.
  - det_en is high for exactly those cycles.
  - prot_gnt rises 1 cycle after det_done.
  - tx_done -> prot_gnt falls; no det_en for 25 cycles.
- Busy line, MAX_RETRY = 3: every check returns result = 0.
  - 4 CHECK windows occur, separated by 64-cycle backoffs.
  - A single prot_fail pulse follows, then return to IDLE.
  - prot_gnt never rises.
- Priority: prot_req and hrst_req rise in the same cycle.
  - hrst_gnt is granted first.
  - After tx_done + 25 cycles IFG, the PROT check starts and prot_gnt follows.
- Preemption: PROT in BACKOFF after 1 busy result, hrst_req asserted.
  - CHECK starts next cycle with owner HRST and retry_cnt = 0.
  - hrst_gnt is granted on an idle result.
- Withdrawal: prot_req drops in BACKOFF -> IDLE with no prot_fail pulse. A stray tx_done in IDLE has no effect.
- Reset: rst_n asserted during GRANT -> all outputs 0 immediately. After release, a new request restarts from CHECK.
